// File: rtl/alu_check_pkg.sv
// Shared types and constants for the 4-bit ALU response checker.
package alu_check_pkg;

    localparam int unsigned OPND_W   = 4;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned RES_W    = 5;
    localparam int unsigned VEC_W    = 11;
    localparam int unsigned SETTLE_W = 4;

    localparam logic [SEL_W-1:0] SEL_ADD  = 2'b00;
    localparam logic [SEL_W-1:0] SEL_SUBC = 2'b01;
    localparam logic [SEL_W-1:0] SEL_PASS = 2'b10;
    localparam logic [SEL_W-1:0] SEL_DEC  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Captured stimulus, packed as {cin,a,b,s}
    typedef struct packed {
        logic              cin;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic [SEL_W-1:0]  s;
    } alu_vec_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the add/subtract/transfer datapath: {cout,d}.
module alu_ref_model
    import alu_check_pkg::*;
(
    input  alu_vec_t         vec,
    output logic [RES_W-1:0] exp_c
);

    logic [OPND_W-1:0] y;

    // Select the second adder operand from s
    always_comb begin
        y = vec.b;
        case (vec.s)
            SEL_ADD:  y = vec.b;
            SEL_SUBC: y = ~vec.b;
            SEL_PASS: y = '0;
            SEL_DEC:  y = '1;
            default:  y = vec.b;
        endcase
    end

    // Full-width sum, carry out lands in the top bit
    assign exp_c = RES_W'(vec.a) + RES_W'(y) + RES_W'(vec.cin);

endmodule

// File: rtl/alu_result_checker.sv
// Handshaked response checker for the 4-bit ALU: settles, latches, compares, tallies.
// Optional first-mismatch capture is built when ALU_CHECK_FIRST_FAIL_EN is defined.
module alu_result_checker
    import alu_check_pkg::*;
#(
    parameter int unsigned NUM_VECTORS   = 2048,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_a,
    input  logic [OPND_W-1:0] in_b,
    input  logic [SEL_W-1:0]  in_s,
    input  logic              in_cin,
    input  logic [OPND_W-1:0] dut_d,
    input  logic              dut_cout,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              busy,
    output logic              done,
    output logic              first_fail_vld,
    output logic [VEC_W-1:0]  first_fail_vec,
    output logic [RES_W-1:0]  first_fail_exp,
    output logic [RES_W-1:0]  first_fail_got
);

    localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]    LAST_VEC   = CNT_W'(NUM_VECTORS - 1);

    state_e              state_q, state_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    alu_vec_t            vec_q, vec_d;
    logic [RES_W-1:0]    got_q, got_d;
    logic [CNT_W-1:0]    vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0]    pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [RES_W-1:0]    ref_exp_c;
    logic                mismatch_c;

    alu_ref_model u_ref (
        .vec   (vec_q),
        .exp_c (ref_exp_c)
    );

    assign mismatch_c = (ref_exp_c != got_q);

    // Next-state, settle counting, latching and tallies
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        vec_d        = vec_q;
        got_d        = got_q;
        vec_cnt_d    = vec_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        err_cnt_d    = err_cnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_WAIT;
                    settle_cnt_d = '0;
                    vec_cnt_d    = '0;
                    pass_cnt_d   = '0;
                    err_cnt_d    = '0;
                end
            end
            ST_WAIT: begin
                if (in_valid && in_ready_q) begin
                    state_d      = ST_CHECK;
                    settle_cnt_d = '0;
                    vec_d        = alu_vec_t'({in_cin, in_a, in_b, in_s});
                    got_d        = {dut_cout, dut_d};
                end else if (in_valid) begin
                    if (settle_cnt_q != SETTLE_MAX) begin
                        settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                    end
                end else begin
                    settle_cnt_d = '0;
                end
            end
            ST_CHECK: begin
                settle_cnt_d = '0;
                vec_cnt_d    = vec_cnt_q + CNT_W'(1);
                if (mismatch_c) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end else begin
                    pass_cnt_d = pass_cnt_q + CNT_W'(1);
                end
                state_d = (vec_cnt_q == LAST_VEC) ? ST_DONE : ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered status outputs track the state being entered
        in_ready_d = (state_d == ST_WAIT) && (settle_cnt_d == SETTLE_MAX);
        busy_d     = (state_d == ST_WAIT) || (state_d == ST_CHECK);
        done_d     = (state_d == ST_DONE);
    end

    // Main state and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            vec_q        <= '0;
            got_q        <= '0;
            vec_cnt_q    <= '0;
            pass_cnt_q   <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            vec_q        <= vec_d;
            got_q        <= got_d;
            vec_cnt_q    <= vec_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass_cnt = pass_cnt_q;
    assign err_cnt  = err_cnt_q;

`ifdef ALU_CHECK_FIRST_FAIL_EN
    logic             ff_vld_q, ff_vld_d;
    alu_vec_t         ff_vec_q, ff_vec_d;
    logic [RES_W-1:0] ff_exp_q, ff_exp_d;
    logic [RES_W-1:0] ff_got_q, ff_got_d;

    // Capture the first mismatch of a run; cleared whenever a run starts
    always_comb begin
        ff_vld_d = ff_vld_q;
        ff_vec_d = ff_vec_q;
        ff_exp_d = ff_exp_q;
        ff_got_d = ff_got_q;
        if (((state_q == ST_IDLE) || (state_q == ST_DONE)) && start) begin
            ff_vld_d = 1'b0;
            ff_vec_d = '0;
            ff_exp_d = '0;
            ff_got_d = '0;
        end else if ((state_q == ST_CHECK) && mismatch_c && !ff_vld_q) begin
            ff_vld_d = 1'b1;
            ff_vec_d = vec_q;
            ff_exp_d = ref_exp_c;
            ff_got_d = got_q;
        end
    end

    // First-fail capture registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ff_vld_q <= 1'b0;
            ff_vec_q <= '0;
            ff_exp_q <= '0;
            ff_got_q <= '0;
        end else begin
            ff_vld_q <= ff_vld_d;
            ff_vec_q <= ff_vec_d;
            ff_exp_q <= ff_exp_d;
            ff_got_q <= ff_got_d;
        end
    end

    assign first_fail_vld = ff_vld_q;
    assign first_fail_vec = ff_vec_q;
    assign first_fail_exp = ff_exp_q;
    assign first_fail_got = ff_got_q;
`else
    assign first_fail_vld = 1'b0;
    assign first_fail_vec = '0;
    assign first_fail_exp = '0;
    assign first_fail_got = '0;
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// Scoreboard bench for alu_result_checker (NUM_VECTORS=4, SETTLE_CYCLES=2).
module tb_alu_result_checker;

    localparam int unsigned CNT_W = 12;
    localparam int          NVEC  = 4;

    logic             clk = 1'b0;
    logic             rst, start, in_valid, in_ready;
    logic [3:0]       in_a, in_b, dut_d;
    logic [1:0]       in_s;
    logic             in_cin, dut_cout;
    logic [CNT_W-1:0] pass_cnt, err_cnt;
    logic             busy, done, first_fail_vld;
    logic [10:0]      first_fail_vec;
    logic [4:0]       first_fail_exp, first_fail_got;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_result_checker #(
        .NUM_VECTORS   (NVEC),
        .SETTLE_CYCLES (2),
        .CNT_W         (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_s           (in_s),
        .in_cin         (in_cin),
        .dut_d          (dut_d),
        .dut_cout       (dut_cout),
        .pass_cnt       (pass_cnt),
        .err_cnt        (err_cnt),
        .busy           (busy),
        .done           (done),
        .first_fail_vld (first_fail_vld),
        .first_fail_vec (first_fail_vec),
        .first_fail_exp (first_fail_exp),
        .first_fail_got (first_fail_got)
    );

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] s;
        logic       cin;
        logic [4:0] exp;   // hand-computed {cout,d}
        logic [4:0] got;   // result presented as the datapath's
    } vec_t;

    typedef struct {
        int         pass_n;
        int         err_n;
        bit         busy;
        bit         done;
        bit         ff_vld;
        logic [10:0] ff_vec;
        logic [4:0] ff_exp;
        logic [4:0] ff_got;
    } exp_item_t;

    exp_item_t sb_q[$];

    int          m_pass, m_err;
    bit          m_ff_vld;
    logic [10:0] m_ff_vec;
    logic [4:0]  m_ff_exp, m_ff_got;

    function automatic vec_t mk(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s,
                                input logic cin, input logic [4:0] e, input logic [4:0] g);
        vec_t v;
        v.a = a; v.b = b; v.s = s; v.cin = cin; v.exp = e; v.got = g;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        m_pass = 0; m_err = 0; m_ff_vld = 1'b0;
        m_ff_vec = '0; m_ff_exp = '0; m_ff_got = '0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        model_clear();
    endtask

    // Present one vector, check settle latency, push expectation; abort=1 resets during CHECK
    task automatic send(input vec_t v, input bit abort);
        exp_item_t it;
        int        lat;
        bit        rdy;
        if (abort) begin
            it = '{0, 0, 1'b0, 1'b0, 1'b0, 11'd0, 5'd0, 5'd0};
        end else begin
            if (v.exp == v.got) m_pass++;
            else begin
                m_err++;
                if (!m_ff_vld) begin
                    m_ff_vld = 1'b1;
                    m_ff_vec = {v.cin, v.a, v.b, v.s};
                    m_ff_exp = v.exp;
                    m_ff_got = v.got;
                end
            end
            it.pass_n = m_pass;
            it.err_n  = m_err;
            it.done   = (m_pass + m_err == NVEC);
            it.busy   = !it.done;
`ifdef ALU_CHECK_FIRST_FAIL_EN
            it.ff_vld = m_ff_vld; it.ff_vec = m_ff_vec; it.ff_exp = m_ff_exp; it.ff_got = m_ff_got;
`else
            it.ff_vld = 1'b0; it.ff_vec = '0; it.ff_exp = '0; it.ff_got = '0;
`endif
        end
        sb_q.push_back(it);
        @(posedge clk); #1;
        in_a = v.a; in_b = v.b; in_s = v.s; in_cin = v.cin;
        {dut_cout, dut_d} = v.got;
        in_valid = 1'b1;
        lat = 0; rdy = 1'b0;
        while (!rdy && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            rdy = in_ready;
        end
        if (!rdy) begin
            chk("ready_timeout", 32'(lat), 32'd2);
            in_valid = 1'b0;
            void'(sb_q.pop_back());
            return;
        end
        chk("ready_latency", 32'(lat), 32'd2);
        @(posedge clk); #1 in_valid = 1'b0;
        if (abort) begin
            rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
            model_clear();
        end
    endtask

    // Monitor: on each observed transfer, compare outputs after the CHECK edge
    initial begin : monitor
        exp_item_t it;
        forever begin
            @(negedge clk);
            if (in_valid && in_ready && !rst) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    it = sb_q.pop_front();
                    @(posedge clk);
                    @(posedge clk);
                    @(negedge clk);
                    chk("mon_pass_cnt", 32'(pass_cnt), 32'(it.pass_n));
                    chk("mon_err_cnt",  32'(err_cnt),  32'(it.err_n));
                    chk("mon_busy",     32'(busy),     32'(it.busy));
                    chk("mon_done",     32'(done),     32'(it.done));
                    chk("mon_in_ready", 32'(in_ready), 32'd0);
                    chk("mon_ff_vld",   32'(first_fail_vld), 32'(it.ff_vld));
                    chk("mon_ff_vec",   32'(first_fail_vec), 32'(it.ff_vec));
                    chk("mon_ff_exp",   32'(first_fail_exp), 32'(it.ff_exp));
                    chk("mon_ff_got",   32'(first_fail_got), 32'(it.ff_got));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        vec_t vtab [8];
        vtab[0] = mk(4'b0101, 4'b0011, 2'b00, 1'b0, 5'b01000, 5'b01000); // basic pass
        vtab[1] = mk(4'b0111, 4'b0010, 2'b01, 1'b1, 5'b10101, 5'b00101); // mismatch
        vtab[2] = mk(4'b0000, 4'b0101, 2'b11, 1'b0, 5'b01111, 5'b01111); // s=11
        vtab[3] = mk(4'b1111, 4'b1010, 2'b10, 1'b1, 5'b10000, 5'b10000); // s=10
        vtab[4] = mk(4'b1001, 4'b1000, 2'b00, 1'b1, 5'b10010, 5'b00010); // mismatch, run 2
        vtab[5] = mk(4'b0011, 4'b0001, 2'b01, 1'b0, 5'b10001, 5'b10001);
        vtab[6] = mk(4'b1111, 4'b0001, 2'b00, 1'b0, 5'b10000, 5'b10000);
        vtab[7] = mk(4'b0001, 4'b0001, 2'b00, 1'b0, 5'b00010, 5'b00010); // aborted by rst

        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_s = '0; in_cin = 1'b0; dut_d = '0; dut_cout = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_pass_cnt", 32'(pass_cnt), 32'd0);
        chk("rst_err_cnt",  32'(err_cnt),  32'd0);
        chk("rst_ff_vld",   32'(first_fail_vld), 32'd0);

        pulse_start();
        @(negedge clk);
        chk("start_busy", 32'(busy), 32'd1);

        // Settle restart: one-cycle valid then a gap must not produce a transfer
        @(posedge clk); #1 in_valid = 1'b1;
        in_a = vtab[0].a; in_b = vtab[0].b; in_s = vtab[0].s; in_cin = vtab[0].cin;
        {dut_cout, dut_d} = vtab[0].got;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("glitch_ready", 32'(in_ready), 32'd0);

        for (int i = 0; i < 4; i++) send(vtab[i], 1'b0);

        // DONE: extra valid is never accepted
        @(posedge clk); #1 in_valid = 1'b1;
        @(negedge clk);
        chk("done_flag", 32'(done), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("done_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1 in_valid = 1'b0;

        pulse_start();
        @(negedge clk);
        chk("restart_pass_cnt", 32'(pass_cnt), 32'd0);
        chk("restart_err_cnt",  32'(err_cnt),  32'd0);
        chk("restart_done",     32'(done),     32'd0);
        chk("restart_busy",     32'(busy),     32'd1);
        chk("restart_ff_vld",   32'(first_fail_vld), 32'd0);

        for (int i = 4; i < 7; i++) send(vtab[i], 1'b0);
        send(vtab[7], 1'b1);

        // rst beats start in the same cycle, then start alone leaves IDLE
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; start = 1'b1;
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_beats_start", 32'(busy), 32'd0);
        pulse_start();
        @(negedge clk);
        chk("start_from_idle", 32'(busy), 32'd1);

        repeat (4) @(posedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
